// File: rtl/imem_responder_pkg.sv
// Shared types, defaults and the address-check helper for the
// instruction-memory responder.
package imem_responder_pkg;

   localparam logic [31:0] PC_BASE_DEFAULT = 32'h8002_0000;
   localparam int          RSP_DW          = 32;
   localparam int          RSP_W           = RSP_DW + 1;

   typedef struct packed {
      logic              err;
      logic [RSP_DW-1:0] data;
   } rsp_t;

   typedef struct packed {
      logic vld;
      rsp_t rsp;
   } pipe_t;

   // True when addr is misaligned or outside [base, base + 4*depth).
   function automatic logic addr_bad(
      input logic [31:0] addr,
      input logic [31:0] base,
      input int unsigned depth_words
   );
      logic [31:0] off;
      off = addr - base;
      return (addr[1:0] != 2'b00) ||
             (addr < base) ||
             ((off >> 2) >= depth_words);
   endfunction

endpackage

// File: rtl/imem_responder_sync_fifo.sv
// Synchronous show-ahead FIFO holding responses awaiting the fetch stage.
// Ports: clk_i, rst_ni, push_i/wdata_i, pop_i, rdata_o (head), empty_o.
module sync_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 3
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             empty_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wp_q;
   logic [PW-1:0]    rp_q;
   logic [CW-1:0]    cnt_q;
   logic             do_push;
   logic             do_pop;

   assign do_push = push_i && (cnt_q != CW'(DEPTH));
   assign do_pop  = pop_i && (cnt_q != '0);

   // Pointer wrap for depths that are not a power of two.
   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wp_q] <= wdata_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wp_q <= nxt(wp_q);
         if (do_pop)  rp_q <= nxt(rp_q);
         unique case (1'b1)
            do_push && !do_pop: cnt_q <= cnt_q + CW'(1);
            do_pop && !do_push: cnt_q <= cnt_q - CW'(1);
            default:            cnt_q <= cnt_q;
         endcase
      end
   end

   assign rdata_o = mem_q[rp_q];
   assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/imem_responder.sv
// Instruction-fetch responder: valid/ready requests in, in-order responses out.
// Ports: clock, reset (async, low), req_*, rsp_*, ld_* load port, ld_err.
module imem_responder
   import imem_responder_pkg::*;
#(
   parameter logic [31:0] PC_BASE_ADDR = PC_BASE_DEFAULT,
   parameter int          DEPTH_WORDS  = 1024,
   parameter int          LATENCY      = 2,
   parameter int          QDEPTH       = LATENCY + 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_err,
   input  logic        ld_en,
   input  logic [31:0] ld_addr,
   input  logic [31:0] ld_data,
   output logic        ld_err
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = $clog2(QDEPTH + 1);

   logic [31:0]      store_q [DEPTH_WORDS];
   pipe_t            pipe_q  [LATENCY];
   pipe_t            pipe_d;
   logic [CW-1:0]    cnt_q;
   logic [CW-1:0]    cnt_d;
   logic             rdy_q;
   logic             ld_err_q;
   logic             accept;
   logic             rsp_hs;
   logic             req_bad;
   logic             ld_bad;
   logic [AW-1:0]    req_idx;
   logic [AW-1:0]    ld_idx;
   logic             fifo_empty;
   logic [RSP_W-1:0] fifo_rdata;
   rsp_t             head;

   assign req_bad = addr_bad(req_addr, PC_BASE_ADDR, DEPTH_WORDS);
   assign ld_bad  = addr_bad(ld_addr, PC_BASE_ADDR, DEPTH_WORDS);
   assign req_idx = AW'((req_addr - PC_BASE_ADDR) >> 2);
   assign ld_idx  = AW'((ld_addr - PC_BASE_ADDR) >> 2);

   assign accept = req_valid && rdy_q;
   assign rsp_hs = rsp_valid && rsp_ready;

   // Store write; the read below samples the old word at the same edge.
   always_ff @(posedge clock) begin
      if (ld_en && !ld_bad) store_q[ld_idx] <= ld_data;
   end

   always_comb begin
      pipe_d         = '0;
      pipe_d.vld     = accept;
      pipe_d.rsp.err = req_bad;
      if (accept && !req_bad) pipe_d.rsp.data = store_q[req_idx];
   end

   always_comb begin
      unique case (1'b1)
         accept && !rsp_hs: cnt_d = cnt_q + CW'(1);
         rsp_hs && !accept: cnt_d = cnt_q - CW'(1);
         default:           cnt_d = cnt_q;
      endcase
   end

   // Ready is registered from the next credit count, so rsp_ready never
   // reaches req_ready combinationally.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
         cnt_q    <= '0;
         rdy_q    <= 1'b0;
         ld_err_q <= 1'b0;
      end else begin
         pipe_q[0] <= pipe_d;
         for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
         cnt_q    <= cnt_d;
         rdy_q    <= (cnt_d < CW'(QDEPTH));
         ld_err_q <= ld_en && ld_bad;
      end
   end

   // Credits bound pipeline + queue occupancy to QDEPTH, so a push
   // always finds room.
   sync_fifo #(
      .WIDTH (RSP_W),
      .DEPTH (QDEPTH)
   ) u_rsp_fifo (
      .clk_i   (clock),
      .rst_ni  (reset),
      .push_i  (pipe_q[LATENCY-1].vld),
      .wdata_i (pipe_q[LATENCY-1].rsp),
      .pop_i   (rsp_hs),
      .rdata_o (fifo_rdata),
      .empty_o (fifo_empty)
   );

   assign head      = fifo_rdata;
   assign req_ready = rdy_q;
   assign rsp_valid = !fifo_empty;
   assign rsp_data  = rsp_valid ? head.data : '0;
   assign rsp_err   = rsp_valid && head.err;
   assign ld_err    = ld_err_q;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: model store plus response scoreboard.
module tb_imem_responder;

   localparam logic [31:0] BASE = 32'h8002_0000;
   localparam int          LAT  = 2;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_addr = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic        ld_en = 1'b0;
   logic [31:0] ld_addr = '0;
   logic [31:0] ld_data = '0;
   logic        ld_err;

   typedef struct {
      logic        err;
      logic [31:0] data;
      int          acc;
      bit          lat;
   } exp_t;

   exp_t        sb [$];
   exp_t        e;
   logic [31:0] mdl [logic [31:0]];
   int          n_chk = 0;
   int          n_err = 0;
   int          cyc = 0;
   bit          lat_mode = 0;
   bit          consec = 0;
   bit          have_last = 0;
   int          last_hs = 0;
   int          acc;

   imem_responder dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .ld_en     (ld_en),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data),
      .ld_err    (ld_err)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic mdl_bad(input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a < BASE) || (a > BASE + 32'hFFC);
   endfunction

   function automatic logic [31:0] mdl_rd(input logic [31:0] a);
      return mdl.exists(a) ? mdl[a] : 32'hx;
   endfunction

   // Expectations are formed before the same-edge load lands in the model.
   always @(negedge clock) begin
      if (reset) begin
         if (req_valid && req_ready) begin
            e.err  = mdl_bad(req_addr);
            e.data = e.err ? 32'h0 : mdl_rd(req_addr);
            e.acc  = cyc + 1;
            e.lat  = lat_mode;
            sb.push_back(e);
         end
         if (ld_en && !mdl_bad(ld_addr)) mdl[ld_addr] = ld_data;
         if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
               chk("unexp_rsp", 64'(rsp_data), 64'h1_0000_0000);
            end else begin
               e = sb.pop_front();
               chk("rsp", 64'({rsp_err, rsp_data}), 64'({e.err, e.data}));
               if (e.lat) chk("latency", 64'(cyc - e.acc), 64'(LAT));
               if (consec && have_last)
                  chk("b2b", 64'(cyc - last_hs), 64'd1);
               last_hs   = cyc;
               have_last = 1;
            end
         end else if (rsp_valid && sb.size() != 0) begin
            chk("hold", 64'({rsp_err, rsp_data}),
                64'({sb[0].err, sb[0].data}));
         end
      end
   end

   task automatic ld(input logic [31:0] a, input logic [31:0] d);
      ld_en   = 1'b1;
      ld_addr = a;
      ld_data = d;
      @(posedge clock);
      #1;
      ld_en = 1'b0;
   endtask

   task automatic send(input logic [31:0] a);
      int n;
      n = 0;
      req_valid = 1'b1;
      req_addr  = a;
      @(negedge clock);
      while (!req_ready && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (!req_ready) chk("send_timeout", 64'd0, 64'd1);
      @(posedge clock);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clock);
         n++;
      end
      chk("drain", 64'(sb.size()), 64'd0);
      @(posedge clock);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clock);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_data", 64'(rsp_data), 64'd0);
      chk("rst_rsp_err", 64'(rsp_err), 64'd0);
      chk("rst_ld_err", 64'(ld_err), 64'd0);
      @(posedge clock);
      #1;
      reset = 1'b1;
      chk("rel_ready", 64'(req_ready), 64'd0);
      @(posedge clock);
      #1;
      chk("first_ready", 64'(req_ready), 64'd1);

      ld(BASE + 32'h000, 32'h2402_0005);
      chk("ld_ok_err", 64'(ld_err), 64'd0);
      ld(BASE + 32'h004, 32'h2403_0007);
      ld(BASE + 32'h008, 32'h0000_0000);
      ld(BASE + 32'h00C, 32'h0000_1111);
      ld(BASE + 32'h010, 32'h0000_2222);
      ld(BASE + 32'hFFC, 32'hCAFE_F00D);

      // back-to-back fetch with latency tracking
      rsp_ready = 1'b1;
      lat_mode  = 1;
      send(BASE + 32'h000);
      send(BASE + 32'h004);
      lat_mode = 0;
      drain();

      // stall until credits run out, then drain in order
      rsp_ready = 1'b0;
      acc = 0;
      req_valid = 1'b1;
      req_addr  = BASE;
      for (int k = 0; k < 10; k++) begin
         @(negedge clock);
         if (!req_ready) break;
         acc++;
         @(posedge clock);
         #1;
         req_addr = BASE + 32'(acc) * 4;
      end
      req_valid = 1'b0;
      chk("credits", 64'(acc), 64'd3);
      repeat (4) @(negedge clock);
      chk("stall_ready", 64'(req_ready), 64'd0);
      consec    = 1;
      have_last = 0;
      @(posedge clock);
      #1;
      rsp_ready = 1'b1;
      drain();
      consec = 0;
      chk("ready_back", 64'(req_ready), 64'd1);

      // error requests interleaved with the last in-range word
      send(BASE + 32'h002);
      send(32'h8001_FFFC);
      send(BASE + 32'h1000);
      send(BASE + 32'hFFC);
      drain();

      // same-edge load and fetch: old word, then new word
      ld_en   = 1'b1;
      ld_addr = BASE + 32'h008;
      ld_data = 32'hDEAD_BEEF;
      send(BASE + 32'h008);
      ld_en = 1'b0;
      send(BASE + 32'h008);
      drain();

      // reset with requests in flight
      rsp_ready = 1'b0;
      send(BASE + 32'h000);
      send(BASE + 32'h004);
      @(posedge clock);
      #1;
      chk("pre_rst_valid", 64'(rsp_valid), 64'd1);
      reset = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
      chk("mid_rst_data", 64'(rsp_data), 64'd0);
      chk("mid_rst_ready", 64'(req_ready), 64'd0);
      sb.delete();
      repeat (2) @(posedge clock);
      #1;
      reset     = 1'b1;
      rsp_ready = 1'b1;
      @(posedge clock);
      #1;
      chk("post_rst_ready", 64'(req_ready), 64'd1);
      repeat (6) @(negedge clock);
      chk("post_rst_quiet", 64'(rsp_valid), 64'd0);
      @(posedge clock);
      #1;
      send(BASE + 32'h000);
      send(BASE + 32'h004);
      drain();

      // misaligned load is dropped and flagged for one cycle
      ld(BASE + 32'h001, 32'h1111_1111);
      chk("ld_err_set", 64'(ld_err), 64'd1);
      @(posedge clock);
      #1;
      chk("ld_err_clr", 64'(ld_err), 64'd0);
      send(BASE + 32'h000);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
